// File: rtl/fetch_unit.sv
// Instruction fetch front-end: in-order word requests, variable-latency in-order
// responses, DEPTH-entry {PC, INST} FIFO toward decode, redirect with in-flight drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ_VALID,
  input  logic        IMEM_REQ_READY,
  output logic [31:0] IMEM_REQ_ADDR,
  input  logic        IMEM_RSP_VALID,
  input  logic [31:0] IMEM_RSP_DATA,
  output logic        IF_VALID,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INST,
  input  logic        IF_READY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] rsp_pc_q, rsp_pc_d;
  cnt_t        live_q, live_d;
  cnt_t        discard_q, discard_d;
  cnt_t        count_q, count_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  logic [31:0] fifo_pc_q   [DEPTH];
  logic [31:0] fifo_inst_q [DEPTH];

  logic [CW:0] live_plus_count;
  logic [CW:0] live_plus_discard;
  logic        accept, rsp_drop, rsp_keep, push, pop;
  logic [31:0] redirect_pc_aligned;
  logic        unused_redirect_low;

  assign redirect_pc_aligned = {REDIRECT_PC[31:2], 2'b00};
  assign unused_redirect_low = ^REDIRECT_PC[1:0];

  assign live_plus_count   = {1'b0, live_q} + {1'b0, count_q};
  assign live_plus_discard = {1'b0, live_q} + {1'b0, discard_q};

  // Credit check: every kept response must have a FIFO slot waiting for it.
  assign IMEM_REQ_VALID = RESET_N && !REDIRECT &&
                          (live_plus_count < DEPTH_W) && (live_plus_discard < DEPTH_W);
  assign IMEM_REQ_ADDR  = fetch_pc_q;

  assign accept   = IMEM_REQ_VALID && IMEM_REQ_READY;
  assign rsp_drop = IMEM_RSP_VALID && (discard_q != '0);
  assign rsp_keep = IMEM_RSP_VALID && (discard_q == '0) && (live_q != '0);
  assign push     = rsp_keep && !REDIRECT;
  assign pop      = (count_q != '0) && IF_READY;

  assign IF_VALID = (count_q != '0);
  assign IF_PC    = fifo_pc_q[rd_ptr_q];
  assign IF_INST  = fifo_inst_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    live_d     = live_q;
    discard_d  = discard_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (REDIRECT) begin
      // Everything still owed to the old stream becomes discard, minus this cycle's arrival.
      discard_d  = discard_q + live_q - cnt_t'(rsp_drop || rsp_keep);
      live_d     = '0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
    end else begin
      live_d    = live_q + cnt_t'(accept) - cnt_t'(rsp_keep);
      discard_d = discard_q - cnt_t'(rsp_drop);
      count_d   = count_q + cnt_t'(push) - cnt_t'(pop);
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      live_q     <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      live_q     <= live_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
    end else if (push) begin
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fifo_inst_q[wr_ptr_q] <= IMEM_RSP_DATA;
    end
  end

  a_credit_bounds: assert property (@(posedge CLK) disable iff (!RESET_N)
    (live_plus_count <= DEPTH_W) && (live_plus_discard <= DEPTH_W));

endmodule
